frequency_meter: RTL and testbench

- Measures the frequency of an asynchronous square-wave input. It counts rising edges of `sig_in` over a gate window of GATE_CYCLES system clocks, then reports the count.
- It is the measuring counterpart of the on-chip clock divider chain. With the default gate of 50_000_000 cycles at 50 MHz, the result reads directly in Hz.
- Feeds display/readout logic through a one-cycle result strobe. Supports single-shot and back-to-back (continuous) measurement.

---
 rtl/frequency_meter.sv | 190 +++++++++++++++++++
 tb/tb_frequency_meter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_meter.sv
// Frequency meter: counts rising edges of an asynchronous square wave over a
// gate window of GATE_CYCLES clk cycles and publishes the count.
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   rst_n       asynchronous active-low reset
//   en          count enable; low freezes the gate window and drops edges
//   start       begin a measurement (honoured only while idle)
//   continuous  sampled at window end; 1 starts the next window with no gap
//   sig_in      asynchronous signal under measurement
//   freq        last completed edge count, held until the next result
//   freq_valid  one-cycle strobe when freq updates
//   overflow    the edge count saturated during the reported window
//   busy        high while a window is being measured
module frequency_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] freq,
  output logic                   freq_valid,
  output logic                   overflow,
  output logic                   busy
);

  // GATE_CYCLES must be at least 2, so the window counter is at least 1 bit.
  localparam int unsigned WinWidth = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WinWidth-1:0] WinLast = WinWidth'(GATE_CYCLES - 1);

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync2_q, prev_q;
  logic edge_det;

  logic [WinWidth-1:0]    win_cnt_q, win_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d, edge_cnt_inc;
  logic                   sat_q, sat_d, sat_inc;

  logic [COUNT_WIDTH-1:0] freq_q, freq_d;
  logic                   overflow_q, overflow_d;
  logic                   freq_valid_q, freq_valid_d;

  logic measuring, tick, win_end, count_edge;

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer followed by a previous-value flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~prev_q;

  // ---------------------------------------------------------------------------
  // Window qualifiers.
  // ---------------------------------------------------------------------------
  assign measuring  = (state_q == StMeasure);
  assign tick       = measuring & en;
  assign win_end    = tick & (win_cnt_q == WinLast);
  assign count_edge = tick & edge_det;

  // Saturating edge count including this cycle's edge. The sat flag marks
  // that an edge arrived while the counter was already at all-ones, i.e. an
  // edge was actually lost.
  always_comb begin
    edge_cnt_inc = edge_cnt_q;
    sat_inc      = sat_q;
    if (count_edge) begin
      if (&edge_cnt_q) begin
        sat_inc = 1'b1;
      end else begin
        edge_cnt_inc = edge_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (win_end && !continuous) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy       = measuring;
    freq       = freq_q;
    freq_valid = freq_valid_q;
    overflow   = overflow_q;
  end

  // ---------------------------------------------------------------------------
  // Window and edge counters.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (!measuring) begin
      if (start) begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
      end
    end else if (win_end) begin
      // Cleared here so a continuous window starts counting next cycle.
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      sat_d      = 1'b0;
    end else if (tick) begin
      win_cnt_d  = win_cnt_q + WinWidth'(1);
      edge_cnt_d = edge_cnt_inc;
      sat_d      = sat_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded only at window end, strobe lasts one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    freq_valid_d = win_end;
    freq_d       = win_end ? edge_cnt_inc : freq_q;
    overflow_d   = win_end ? sat_inc : overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q       <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      freq_q       <= freq_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Self-checking bench for frequency_meter. Two instances share all inputs:
// a 32-bit counter and a 4-bit counter (for saturation). Every cycle's inputs
// and outputs are logged; a reference model recomputes the expected strobes,
// results and busy from the logged inputs using window arithmetic.
module tb_frequency_meter;

  localparam int unsigned Gate = 100;
  localparam int MaxCyc = 8192;

  logic clk = 1'b0;
  logic rst_n, en, start, continuous, sig_in;
  logic [31:0] freq;
  logic        freq_valid, overflow, busy;
  logic [3:0]  freq4;
  logic        freq_valid4, overflow4, busy4;

  frequency_meter #(.GATE_CYCLES(Gate), .COUNT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .continuous(continuous),
    .sig_in    (sig_in),
    .freq      (freq),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  frequency_meter #(.GATE_CYCLES(Gate), .COUNT_WIDTH(4)) dut_w4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .continuous(continuous),
    .sig_in    (sig_in),
    .freq      (freq4),
    .freq_valid(freq_valid4),
    .overflow  (overflow4),
    .busy      (busy4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Square-wave generator: high for the first half of each period.
  int gen_period = 10;
  int gen_phase = 0;
  bit gen_freeze = 1'b0;

  // Per-cycle log; index n is the n-th rising clk edge since reset release.
  bit          h_sig[MaxCyc], h_en[MaxCyc], h_start[MaxCyc], h_cont[MaxCyc];
  bit          o_valid[MaxCyc], o_busy[MaxCyc], o_ovf[MaxCyc];
  bit          o_valid4[MaxCyc], o_busy4[MaxCyc], o_ovf4[MaxCyc];
  logic [31:0] o_freq[MaxCyc];
  logic [3:0]  o_freq4[MaxCyc];

  bit e_valid[MaxCyc], e_busy[MaxCyc];
  int e_res[MaxCyc];

  typedef struct {
    int          period;
    int          phase;
    logic [31:0] exp_freq;
    logic [3:0]  exp_freq4;
    bit          exp_ovf4;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_at(input string tag, input string what, input int idx,
                          input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s @cycle %0d: got %0d, expected %0d", tag, what, idx, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " freq"}, freq, 0);
    check({tag, " freq_valid"}, freq_valid, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " freq(w4)"}, freq4, 0);
    check({tag, " freq_valid(w4)"}, freq_valid4, 0);
    check({tag, " overflow(w4)"}, overflow4, 0);
    check({tag, " busy(w4)"}, busy4, 0);
  endtask

  // Called at a falling edge: drives sig_in, logs inputs, lets one rising edge
  // pass and logs the outputs at the next falling edge.
  task automatic step();
    if (cyc >= MaxCyc) begin
      $display("FAIL history: cycle log exhausted at %0d", cyc);
      $fatal(1, "cycle log exhausted");
    end
    if (!gen_freeze) sig_in = ((cyc + gen_phase) % gen_period) < (gen_period / 2);
    h_sig[cyc]   = sig_in;
    h_en[cyc]    = en;
    h_start[cyc] = start;
    h_cont[cyc]  = continuous;
    @(posedge clk);
    @(negedge clk);
    o_valid[cyc]  = freq_valid;
    o_busy[cyc]   = busy;
    o_ovf[cyc]    = overflow;
    o_freq[cyc]   = freq;
    o_valid4[cyc] = freq_valid4;
    o_busy4[cyc]  = busy4;
    o_ovf4[cyc]   = overflow4;
    o_freq4[cyc]  = freq4;
    cyc++;
  endtask

  task automatic wait_valid(input int budget, output int label);
    label = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (o_valid[cyc-1]) begin
        label = cyc - 1;
        break;
      end
    end
  endtask

  function automatic bit samp(input int i);
    return (i < 0) ? 1'b0 : h_sig[i];
  endfunction

  // Reference model. A start seen while idle at edge q opens a window; the
  // window closes on the Gate-th enabled edge after q. An edge of sig_in
  // sampled at edge k is credited at edge k+2 if that edge is enabled and in
  // the window. The result appears at the closing edge.
  task automatic check_epoch(input string tag);
    int pos, q, e, n_en, edges, cur;
    bit done;
    for (int i = 0; i < cyc; i++) begin
      e_valid[i] = 1'b0;
      e_busy[i]  = 1'b0;
      e_res[i]   = -1;
    end
    pos = 0;
    while (pos < cyc) begin
      q = pos;
      while (q < cyc && !h_start[q]) q++;
      if (q >= cyc) break;
      done = 1'b0;
      while (!done) begin
        n_en = 0;
        edges = 0;
        e = q;
        while (n_en < Gate && e < cyc - 1) begin
          e++;
          if (h_en[e]) begin
            n_en++;
            if (samp(e - 2) && !samp(e - 3)) edges++;
          end
        end
        if (n_en < Gate) begin
          for (int k = q; k < cyc; k++) e_busy[k] = 1'b1;
          done = 1'b1;
          pos = cyc;
        end else begin
          for (int k = q; k < e; k++) e_busy[k] = 1'b1;
          e_valid[e] = 1'b1;
          e_res[e] = edges;
          if (h_cont[e]) q = e;
          else begin
            done = 1'b1;
            pos = e + 1;
          end
        end
      end
    end
    cur = 0;
    for (int i = 0; i < cyc; i++) begin
      if (e_res[i] >= 0) cur = e_res[i];
      check_at(tag, "freq_valid", i, o_valid[i], e_valid[i]);
      check_at(tag, "busy", i, o_busy[i], e_busy[i]);
      check_at(tag, "freq", i, o_freq[i], cur);
      check_at(tag, "overflow", i, o_ovf[i], 0);
      check_at(tag, "freq_valid(w4)", i, o_valid4[i], e_valid[i]);
      check_at(tag, "busy(w4)", i, o_busy4[i], e_busy[i]);
      check_at(tag, "freq(w4)", i, o_freq4[i], (cur > 15) ? 15 : cur);
      check_at(tag, "overflow(w4)", i, o_ovf4[i], (cur > 15) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tv, prev, drops, len;

    vecs = '{
      '{10, 3, 32'd10, 4'd10, 1'b0},
      '{4, 1, 32'd25, 4'd15, 1'b1},
      '{20, 7, 32'd5, 4'd5, 1'b0},
      '{5, 0, 32'd20, 4'd15, 1'b1},
      '{25, 11, 32'd4, 4'd4, 1'b0},
      '{50, 20, 32'd2, 4'd2, 1'b0}
    };

    rst_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    sig_in = 1'b0;

    // Reset held with sig_in toggling.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Single-shot table.
    for (int r = 0; r < 6; r++) begin
      gen_period = vecs[r].period;
      gen_phase = vecs[r].phase;
      continuous = 1'b0;
      en = 1'b1;
      repeat (10) step();
      t0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("row%0d busy after start", r), o_busy[t0], 1);
      wait_valid(300, tv);
      check($sformatf("row%0d strobe latency", r), tv - t0, Gate);
      if (tv >= 0) begin
        check($sformatf("row%0d freq", r), o_freq[tv], vecs[r].exp_freq);
        check($sformatf("row%0d overflow", r), o_ovf[tv], 0);
        check($sformatf("row%0d freq(w4)", r), o_freq4[tv], vecs[r].exp_freq4);
        check($sformatf("row%0d overflow(w4)", r), o_ovf4[tv], vecs[r].exp_ovf4);
      end
      repeat (5) step();
      check($sformatf("row%0d busy after result", r), o_busy[cyc-1], 0);
    end

    // Continuous: three back-to-back windows, then drop continuous.
    gen_period = 4;
    gen_phase = 2;
    continuous = 1'b1;
    repeat (10) step();
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    prev = t0;
    for (int w = 0; w < 4; w++) begin
      wait_valid(150, tv);
      check($sformatf("cont window%0d interval", w), tv - prev, Gate);
      if (tv >= 0) begin
        check($sformatf("cont window%0d freq", w), o_freq[tv], 25);
        check($sformatf("cont window%0d freq(w4)", w), o_freq4[tv], 15);
        check($sformatf("cont window%0d overflow(w4)", w), o_ovf4[tv], 1);
        prev = tv;
      end
      if (w == 2) continuous = 1'b0;
    end
    drops = 0;
    for (int i = t0; i < prev; i++) if (!o_busy[i]) drops++;
    check("cont busy drops", drops, 0);
    repeat (3) step();
    check("cont idle after final", o_busy[cyc-1], 0);

    // Enable freeze: 50 disabled cycles starting inside a low plateau of
    // sig_in, with sig_in held; a mid-window start must have no effect.
    gen_period = 10;
    gen_phase = 0;
    en = 1'b1;
    repeat (10) step();
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    for (int k = 0; k < 10 && ((cyc + gen_phase) % 10) != 8; k++) step();
    en = 1'b0;
    gen_freeze = 1'b1;
    repeat (20) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    en = 1'b1;
    gen_freeze = 1'b0;
    wait_valid(200, tv);
    check("freeze strobe latency", tv - t0, Gate + 50);
    if (tv >= 0) check("freeze freq", o_freq[tv], 10);

    // Reset mid-window, asserted between clock edges.
    repeat (10) step();
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    check("pre-reset busy", o_busy[cyc-1], 1);
    check_epoch("epoch1");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sig_in = ~sig_in;
      start = (k == 3);
      check($sformatf("in reset freq_valid %0d", k), freq_valid, 0);
      check($sformatf("in reset busy %0d", k), busy, 0);
    end
    check_reset_outputs("reset held");
    start = 1'b0;
    en = 1'b1;
    continuous = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Fresh measurement after reset.
    gen_period = 5;
    gen_phase = 1;
    repeat (10) step();
    check("post-reset freq held", o_freq[cyc-1], 0);
    t0 = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(300, tv);
    check("post-reset strobe latency", tv - t0, Gate);
    if (tv >= 0) check("post-reset freq", o_freq[tv], 20);

    // Random traffic checked against the reference model.
    for (int blk = 0; blk < 40; blk++) begin
      gen_period = $urandom_range(4, 40);
      gen_phase = $urandom_range(0, 39);
      continuous = $urandom_range(0, 1);
      len = $urandom_range(20, 80);
      for (int k = 0; k < len; k++) begin
        en = ($urandom_range(0, 7) != 0);
        start = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    en = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (250) step();
    check_epoch("epoch2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
